// File: rtl/vi_mem_pkg.sv
// Shared types and defaults for the vi_main_mem line memory.
package vi_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } mem_state_e;

   localparam int unsigned ADDR_W_DEF  = 20;
   localparam int unsigned LINE_W_DEF  = 128;
   localparam int unsigned WORD_W_DEF  = 32;
   localparam int unsigned DEPTH_DEF   = 4096;
   localparam int unsigned LATENCY_DEF = 3;

   // Number of byte-offset bits inside one line.
   function automatic int unsigned off_w(input int unsigned line_w);
      return $clog2(line_w / 8);
   endfunction

   localparam int unsigned OFF_W_DEF = off_w(LINE_W_DEF);

endpackage

// File: rtl/vi_mem_lat_ctr.sv
// Access-latency down-counter: loads LATENCY-1 on accept, zero_c marks the final wait cycle.
module vi_mem_lat_ctr
   import vi_mem_pkg::*;
#(
   parameter int unsigned LATENCY = LATENCY_DEF
) (
   input  logic clk_i,
   input  logic rsn_i,
   input  logic load_i,
   output logic zero_c
);

   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(LATENCY - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/vi_main_mem.sv
// Fixed-latency line memory: line reads, word/byte writes, one access in flight.
// Define VI_MEM_BOUNDS_CHK_EN to flag line indices >= DEPTH instead of wrapping them.
module vi_main_mem
   import vi_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned LINE_W  = LINE_W_DEF,
   parameter int unsigned WORD_W  = WORD_W_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned LATENCY = LATENCY_DEF
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic              wr_byte_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic              busy_o,
   output logic              data_ready_o,
   output logic [LINE_W-1:0] data_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              err_o
);

   localparam int unsigned OFF_W  = off_w(LINE_W);
   localparam int unsigned IDX_W  = ADDR_W - OFF_W;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BIT_W  = OFF_W + 3;
   localparam logic [OFF_W-1:0] WORD_MASK = OFF_W'(WORD_W / 8 - 1);
   localparam logic [IDX_W:0]   DEPTH_X   = (IDX_W + 1)'(DEPTH);

`ifdef VI_MEM_BOUNDS_CHK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] op_addr_q, op_addr_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic              wr_byte_q, wr_byte_d;
   logic              oob_q, oob_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;

   logic              ctr_load_c;
   logic              ctr_zero_c;
   logic              mem_we_c;
   logic [LINE_W-1:0] mem_wline_c;
   logic [IDX_W-1:0]  rd_idx_c, wr_idx_c, op_idx_c;
   logic              rd_oob_c, wr_oob_c;
   logic [OFF_W-1:0]  op_off_c;
   logic [BIT_W-1:0]  byte_base_c, word_base_c;

   logic [LINE_W-1:0] mem_q [DEPTH];

   vi_mem_lat_ctr #(
      .LATENCY (LATENCY)
   ) u_lat_ctr (
      .clk_i  (clk_i),
      .rsn_i  (rsn_i),
      .load_i (ctr_load_c),
      .zero_c (ctr_zero_c)
   );

   // Line index / offset split; indices >= DEPTH wrap unless bounds checking is built in.
   always_comb begin
      rd_idx_c    = rd_addr_i[ADDR_W-1:OFF_W];
      wr_idx_c    = wr_addr_i[ADDR_W-1:OFF_W];
      op_idx_c    = op_addr_q[ADDR_W-1:OFF_W];
      op_off_c    = op_addr_q[OFF_W-1:0];
      rd_oob_c    = BOUNDS_EN && ({1'b0, rd_idx_c} >= DEPTH_X);
      wr_oob_c    = BOUNDS_EN && ({1'b0, wr_idx_c} >= DEPTH_X);
      byte_base_c = {op_off_c, 3'b000};
      word_base_c = {op_off_c & ~WORD_MASK, 3'b000};
   end

   // Read-modify-write image of the target line at the commit edge.
   always_comb begin
      mem_wline_c = mem_q[op_idx_c[MEM_AW-1:0]];
      if (wr_byte_q) begin
         mem_wline_c[byte_base_c +: 8] = wr_data_q[7:0];
      end else begin
         mem_wline_c[word_base_c +: WORD_W] = wr_data_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_addr_d  = op_addr_q;
      wr_data_d  = wr_data_q;
      wr_byte_d  = wr_byte_q;
      oob_d      = oob_q;
      line_d     = line_q;
      data_d     = data_q;
      addr_d     = addr_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      ctr_load_c = 1'b0;
      mem_we_c   = 1'b0;

      case (state_q)
         IDLE: begin
            // Read wins a same-cycle collision; the write is simply not taken.
            if (rd_req_i) begin
               state_d    = RD_WAIT;
               op_addr_d  = rd_addr_i;
               oob_d      = rd_oob_c;
               line_d     = mem_q[rd_idx_c[MEM_AW-1:0]];
               ctr_load_c = 1'b1;
            end else if (wr_en_i) begin
               state_d    = WR_WAIT;
               op_addr_d  = wr_addr_i;
               wr_data_d  = wr_data_i;
               wr_byte_d  = wr_byte_i;
               oob_d      = wr_oob_c;
               ctr_load_c = 1'b1;
            end
         end
         RD_WAIT: begin
            if (ctr_zero_c) begin
               state_d = RESP;
               data_d  = oob_q ? '0 : line_q;
               addr_d  = op_addr_q;
               ready_d = 1'b1;
               err_d   = oob_q;
            end
         end
         WR_WAIT: begin
            if (ctr_zero_c) begin
               state_d  = IDLE;
               mem_we_c = ~oob_q;
               err_d    = oob_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RD_WAIT) || (state_d == WR_WAIT);
   end

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         state_q   <= IDLE;
         op_addr_q <= '0;
         wr_data_q <= '0;
         wr_byte_q <= 1'b0;
         oob_q     <= 1'b0;
         line_q    <= '0;
         data_q    <= '0;
         addr_q    <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_addr_q <= op_addr_d;
         wr_data_q <= wr_data_d;
         wr_byte_q <= wr_byte_d;
         oob_q     <= oob_d;
         line_q    <= line_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we_c) begin
         mem_q[op_idx_c[MEM_AW-1:0]] <= mem_wline_c;
      end
   end

   assign busy_o       = busy_q;
   assign data_ready_o = ready_q;
   assign data_o       = data_q;
   assign addr_o       = addr_q;
   assign err_o        = err_q;

endmodule
